// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arithmetic ops and iterative
// shift-add multiply / restoring divide (one bit per clock).
`default_nettype none

module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_MULU = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             is_div;
  logic [WIDTH-1:0] acc_hi;   // partial product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // multiplier being shifted out / quotient shifting in
  logic [WIDTH-1:0] opnd;     // multiplicand or divisor
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic             iterative;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_MULU: alu_res = '0;
      OP_DIVU: alu_res = '1;
      default: alu_res = '0;
    endcase
  end

  assign iterative = (op == OP_MULU) || ((op == OP_DIVU) && (B != '0));

  // One iteration step; the divide borrow (MSB of div_diff) selects restore.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    step_hi   = '0;
    step_lo   = '0;
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      is_div    <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      opnd      <= '0;
      cnt       <= '0;
      result    <= '0;
      result_hi <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      zero      <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= step_lo;
            result_hi <= step_hi;
            zero      <= (step_lo == '0);
            dbz       <= 1'b0;
          end
        end
        default: begin
          if (start) begin
            if (iterative) begin
              state  <= RUN;
              busy   <= 1'b1;
              is_div <= op[0];
              opnd   <= B;
              acc_hi <= '0;
              acc_lo <= A;
              cnt    <= '0;
            end else begin
              state     <= DONE;
              done      <= 1'b1;
              result    <= alu_res;
              result_hi <= (op == OP_DIVU) ? A : '0;
              zero      <= (alu_res == '0);
              dbz       <= (op == OP_DIVU);
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table, directed and random checks of alu_seq at WIDTH=32 and WIDTH=8
// against an arithmetic reference model.
`default_nettype none

module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start32 = 1'b0, start8 = 1'b0;
  logic [2:0]  op32 = '0, op8 = '0;
  logic [31:0] a32 = '0, b32 = '0, res32, hi32;
  logic [7:0]  a8 = '0, b8 = '0, res8, hi8;
  logic        busy32, done32, zero32, dbz32;
  logic        busy8, done8, zero8, dbz8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .A(a32), .B(b32),
    .result(res32), .result_hi(hi32), .busy(busy32), .done(done32),
    .zero(zero32), .dbz(dbz32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
    .result(res8), .result_hi(hi8), .busy(busy8), .done(done8),
    .zero(zero8), .dbz(dbz8)
  );

  typedef struct {
    string       nm;
    int          w;
    logic [2:0]  op;
    logic [63:0] a, b, lo, hi;
    logic        z, d;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  function automatic logic        d_done(int w); return (w == 8) ? done8 : done32; endfunction
  function automatic logic        d_busy(int w); return (w == 8) ? busy8 : busy32; endfunction
  function automatic logic [63:0] d_lo(int w);   return (w == 8) ? {56'b0, res8} : {32'b0, res32}; endfunction
  function automatic logic [63:0] d_hi(int w);   return (w == 8) ? {56'b0, hi8}  : {32'b0, hi32};  endfunction
  function automatic logic        d_zero(int w); return (w == 8) ? zero8 : zero32; endfunction
  function automatic logic        d_dbz(int w);  return (w == 8) ? dbz8 : dbz32; endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Reference: plain arithmetic on wide integers, masked to w bits.
  task automatic model(input int w, input logic [2:0] o, input logic [63:0] ai, input logic [63:0] bi,
                       output logic [63:0] lo, output logic [63:0] hi, output logic z,
                       output logic d, output int lat);
    logic [63:0]  mask = (64'd1 << w) - 64'd1;
    logic [63:0]  a = ai & mask;
    logic [63:0]  b = bi & mask;
    logic [127:0] p;
    longint       sa, sb;
    lo = 0; hi = 0; d = 0; lat = 0;
    case (o)
      3'd0: lo = (a + b) & mask;
      3'd1: lo = (a - b) & mask;
      3'd2: lo = a & b;
      3'd3: lo = a | b;
      3'd4: lo = a ^ b;
      3'd5: begin
        sa = longint'(a); if (a[w-1]) sa = sa - (longint'(1) << w);
        sb = longint'(b); if (b[w-1]) sb = sb - (longint'(1) << w);
        lo = (sa < sb) ? 64'd1 : 64'd0;
      end
      3'd6: begin
        p   = {64'b0, a} * {64'b0, b};
        lo  = p[63:0] & mask;
        hi  = (p >> w) & {64'b0, mask};
        lat = w;
      end
      default: begin
        if (b == 0) begin
          lo = mask; hi = a; d = 1'b1;
        end else begin
          lo = a / b; hi = a % b; lat = w;
        end
      end
    endcase
    z = (lo == 0);
  endtask

  task automatic drive(input int w, input logic s, input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    if (w == 8) begin start8 = s; op8 = o; a8 = a[7:0]; b8 = b[7:0]; end
    else begin start32 = s; op32 = o; a32 = a[31:0]; b32 = b[31:0]; end
  endtask

  // Returns with done visible; lat = edges after the accepting edge.
  task automatic wait_done(input int w, output int lat, output int bc);
    lat = 0; bc = 0;
    while (!d_done(w) && lat < 200) begin
      if (d_busy(w)) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_and_check(input string nm, input int w, input logic [2:0] o,
                               input logic [63:0] a, input logic [63:0] b,
                               input logic [63:0] elo, input logic [63:0] ehi,
                               input logic ez, input logic ed, input int elat);
    int lat, bc;
    @(negedge clk);
    drive(w, 1'b1, o, a, b);
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    wait_done(w, lat, bc);
    check({nm, " result"}, d_lo(w), elo);
    check({nm, " result_hi"}, d_hi(w), ehi);
    check({nm, " zero"}, {63'b0, d_zero(w)}, {63'b0, ez});
    check({nm, " dbz"}, {63'b0, d_dbz(w)}, {63'b0, ed});
    check({nm, " latency"}, 64'(lat), 64'(elat));
    check({nm, " busy cycles"}, 64'(bc), 64'(elat));
    @(posedge clk); #1;
    check({nm, " done pulse"}, {63'b0, d_done(w)}, 64'd0);
    check({nm, " result hold"}, d_lo(w), elo);
  endtask

  function automatic vec_t mk(string nm, int w, logic [2:0] o, logic [63:0] a, logic [63:0] b,
                              logic [63:0] lo, logic [63:0] hi, logic z, logic d, int lat);
    vec_t v;
    v.nm = nm; v.w = w; v.op = o; v.a = a; v.b = b; v.lo = lo; v.hi = hi;
    v.z = z; v.d = d; v.lat = lat;
    return v;
  endfunction

  initial begin
    logic [63:0] elo, ehi, ra, rb;
    logic        ez, ed;
    int          elat, lat, bc, w;
    logic [2:0]  ro;

    tbl.push_back(mk("add32",   32, 3'd0, 64'hCCCCCCCC, 64'h33333333, 64'hFFFFFFFF, 0, 0, 0, 0));
    tbl.push_back(mk("mulu32",  32, 3'd6, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1, 64'hFFFFFFFE, 0, 0, 32));
    tbl.push_back(mk("divu32",  32, 3'd7, 64'd100, 64'd7, 64'd14, 64'd2, 0, 0, 32));
    tbl.push_back(mk("dbz32",   32, 3'd7, 64'd5, 64'd0, 64'hFFFFFFFF, 64'd5, 0, 1, 0));
    tbl.push_back(mk("slt32",   32, 3'd5, 64'hFFFFFFFF, 64'd1, 64'd1, 0, 0, 0, 0));
    tbl.push_back(mk("slt32n",  32, 3'd5, 64'd1, 64'hFFFFFFFF, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("sub32",   32, 3'd1, 64'd5, 64'd5, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("and32",   32, 3'd2, 64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 0, 0, 0, 0));
    tbl.push_back(mk("or32",    32, 3'd3, 64'h0F0F0000, 64'h000000FF, 64'h0F0F00FF, 0, 0, 0, 0));
    tbl.push_back(mk("xor32",   32, 3'd4, 64'hA5A5A5A5, 64'hFFFFFFFF, 64'h5A5A5A5A, 0, 0, 0, 0));
    tbl.push_back(mk("addwrap", 32, 3'd0, 64'hFFFFFFFF, 64'd1, 64'd0, 0, 1, 0, 0));
    tbl.push_back(mk("mulhi",   32, 3'd6, 64'h10000, 64'h10000, 64'd0, 64'd1, 1, 0, 32));
    tbl.push_back(mk("divsm",   32, 3'd7, 64'd7, 64'd100, 64'd0, 64'd7, 1, 0, 32));
    tbl.push_back(mk("mulu8",   8,  3'd6, 64'hFF, 64'hFF, 64'h01, 64'hFE, 0, 0, 8));
    tbl.push_back(mk("divu8",   8,  3'd7, 64'd200, 64'd7, 64'd28, 64'd4, 0, 0, 8));
    tbl.push_back(mk("add8",    8,  3'd0, 64'hF0, 64'h10, 64'h00, 0, 1, 0, 0));
    tbl.push_back(mk("slt8",    8,  3'd5, 64'h80, 64'h01, 64'h01, 0, 0, 0, 0));
    tbl.push_back(mk("dbz8",    8,  3'd7, 64'h09, 64'h00, 64'hFF, 64'h09, 0, 1, 0));

    // Reset state
    #2 rst = 1'b0;
    #4;
    check("reset result", {32'b0, res32}, 64'd0);
    check("reset busy/done/zero/dbz", {60'b0, busy32, done32, zero32, dbz32}, 64'd0);
    @(negedge clk) rst = 1'b1;

    foreach (tbl[i])
      run_and_check(tbl[i].nm, tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].lo, tbl[i].hi, tbl[i].z, tbl[i].d, tbl[i].lat);

    // Start during RUN is ignored
    model(32, 3'd6, 64'h12345678, 64'h9ABCDEF0, elo, ehi, ez, ed, elat);
    @(negedge clk); drive(32, 1'b1, 3'd6, 64'h12345678, 64'h9ABCDEF0);
    @(posedge clk); #1; start32 = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); drive(32, 1'b1, 3'd0, 64'd1, 64'd2);
    @(posedge clk); #1; start32 = 1'b0;
    check("ignored start busy", {63'b0, busy32}, 64'd1);
    wait_done(32, lat, bc);
    check("ignored start latency", 64'(lat + 5), 64'd32);
    check("ignored start result", {32'b0, res32}, elo);
    check("ignored start result_hi", {32'b0, hi32}, ehi);

    // Asynchronous reset mid-RUN, with nonzero held outputs from a divide-by-zero
    run_and_check("pre-reset dbz", 32, 3'd7, 64'd5, 64'd0, 64'hFFFFFFFF, 64'd5, 0, 1, 0);
    @(negedge clk); drive(32, 1'b1, 3'd6, 64'hFFFFFFFF, 64'h3);
    @(posedge clk); #1; start32 = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async reset result", {32'b0, res32}, 64'd0);
    check("async reset result_hi", {32'b0, hi32}, 64'd0);
    check("async reset flags", {60'b0, busy32, done32, zero32, dbz32}, 64'd0);
    @(negedge clk) rst = 1'b1;
    run_and_check("post-reset add", 32, 3'd0, 64'd3, 64'd4, 64'd7, 0, 0, 0, 0);

    // Back-to-back: ADD accepted in the DONE cycle of a MULU
    @(negedge clk); drive(32, 1'b1, 3'd6, 64'd1000, 64'd1000);
    @(posedge clk); #1; start32 = 1'b0;
    wait_done(32, lat, bc);
    check("b2b mulu result", {32'b0, res32}, 64'd1000000);
    drive(32, 1'b1, 3'd0, 64'h11, 64'h22);
    @(posedge clk); #1; start32 = 1'b0;
    check("b2b second done", {63'b0, done32}, 64'd1);
    check("b2b add result", {32'b0, res32}, 64'h33);
    check("b2b add result_hi", {32'b0, hi32}, 64'd0);
    // DONE of the ADD: start an iterative DIVU, done must drop
    drive(32, 1'b1, 3'd7, 64'd100, 64'd7);
    @(posedge clk); #1; start32 = 1'b0;
    check("b2b divu done low", {63'b0, done32}, 64'd0);
    check("b2b divu busy", {63'b0, busy32}, 64'd1);
    wait_done(32, lat, bc);
    check("b2b divu latency", 64'(lat), 64'd32);
    check("b2b divu result", {32'b0, res32}, 64'd14);

    // Same back-to-back at WIDTH=8
    @(negedge clk); drive(8, 1'b1, 3'd6, 64'hFF, 64'hFF);
    @(posedge clk); #1; start8 = 1'b0;
    wait_done(8, lat, bc);
    check("b2b8 mulu latency", 64'(lat), 64'd8);
    check("b2b8 mulu result_hi", {56'b0, hi8}, 64'hFE);
    drive(8, 1'b1, 3'd0, 64'h05, 64'h06);
    @(posedge clk); #1; start8 = 1'b0;
    check("b2b8 second done", {63'b0, done8}, 64'd1);
    check("b2b8 add result", {56'b0, res8}, 64'h0B);

    // Random ops against the model
    for (int i = 0; i < 150; i++) begin
      w  = (i % 3 == 0) ? 8 : 32;
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 5) == 0) rb = 64'd0;
      if ($urandom_range(0, 7) == 0) rb = ra;
      model(w, ro, ra, rb, elo, ehi, ez, ed, elat);
      run_and_check($sformatf("rand%0d op%0d w%0d", i, ro, w), w, ro, ra, rb, elo, ehi, ez, ed, elat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-004 start  input  1  request; operands/opcode sampled when accepted.
REQ-005 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 MULU, 111 DIVU.
REQ-006 A  input  WIDTH  operand A.
REQ-007 B  input  WIDTH  operand B.
REQ-008 result  output  WIDTH  primary result (low product, quotient, or single-cycle op result).
REQ-009 result_hi  output  WIDTH  high product (MULU), remainder (DIVU), zero for all other ops.
REQ-010 busy  output  1  high while an iterative op is in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 zero  output  1  high when result == 0; valid with done, held afterwards.
REQ-013 dbz  output  1  divide-by-zero flag for the last DIVU; zero for other ops.

Function
REQ-014 FSM states IDLE, RUN, DONE; done=1 only in DONE; busy=1 only in RUN.
REQ-015 start accepted on a rising edge when state is IDLE or DONE; A, B, op captured at that edge.
REQ-016 start while busy=1 is ignored; the in-flight op continues unaffected.
REQ-017 Ops 000-101 and DIVU with B==0: result written at the accepting edge, state -> DONE; done high for the following cycle (latency 1).
REQ-018 ADD/SUB modulo 2^WIDTH; SLT signed two's complement, result = {0..0,1} if A<B else 0.
REQ-019 MULU: unsigned shift-add, one iteration per edge, WIDTH iterations; {result_hi,result} = full 2*WIDTH-bit product.
REQ-020 DIVU (B!=0): unsigned restoring division, one quotient bit per edge, WIDTH iterations; result=quotient, result_hi=remainder.
REQ-021 Iterative timing: accept at edge k -> RUN; iterations at edges k+1..k+WIDTH; DONE entered at edge k+WIDTH; done high during the next cycle.
REQ-022 Iteration counter width ceil(log2(WIDTH))+1; terminates exactly after WIDTH iterations, no wrap.
REQ-023 DIVU with B==0: result = all ones, result_hi = A, dbz=1, no RUN state.
REQ-024 result, result_hi, zero, dbz hold their values from DONE until the next accepted start; intermediate values not exposed during RUN.
REQ-025 start in the DONE cycle is accepted (back-to-back); done then deasserts unless the new op is single-cycle, in which case done stays high a second cycle with new results.
REQ-026 No combinational path from inputs to outputs.

Reset
REQ-027 rst low at any time, including mid-RUN, forces state IDLE and result, result_hi, busy, done, zero, dbz, counter to 0 immediately, without a clock.
REQ-028 After rst deasserts, first start is accepted at the first rising edge it is sampled high.

Verification
REQ-029 WIDTH=32, ADD A=0xCCCCCCCC B=0x33333333 -> result 0xFFFFFFFF, result_hi 0, zero 0, done one edge after start.
REQ-030 MULU A=0xFFFFFFFF B=0xFFFFFFFF -> result 0x00000001, result_hi 0xFFFFFFFE, busy high 32 cycles, done 32 edges after start.
REQ-031 DIVU A=100 B=7 -> result 14, result_hi 2, dbz 0; DIVU A=5 B=0 -> result 0xFFFFFFFF, result_hi 5, dbz 1, done after one edge.
REQ-032 SLT A=0xFFFFFFFF B=1 -> result 1; SUB A=5 B=5 -> result 0, zero 1.
REQ-033 MULU started, start pulsed again at cycle 5 with op=ADD -> ignored, MULU result unchanged; rst low at cycle 10 of a second MULU -> all outputs 0 asynchronously, next start completes normally.
REQ-034 Back-to-back: ADD accepted in DONE of a MULU -> done high two consecutive cycles, second with ADD result; repeat checks at WIDTH=8 (MULU 0xFF*0xFF -> result_hi 0xFE, result 0x01, 8 cycles).
